// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running counter bus: lock, slip, restart, errors.
// Define COUNT_SEQ_CHECKER_WRAP_EN to accept the all-ones -> 0 wrap as in-sequence.
module count_seq_checker #(
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 restart_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state
);

  localparam int RUN_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST =
    RUN_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    SLIP    = 2'd2,
    BAD     = 2'd3
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     prev_q;
  logic                 has_prev_q;
  logic [RUN_W-1:0]     run_q;
  logic                 locked_q;
  logic                 err_q;
  logic                 rst_pls_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic [WIDTH-1:0]     prev_inc_d;
  logic                 seq_d;
  logic                 wrap_d;
  logic                 good_d;
  logic                 zero_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  assign prev_inc_d = prev_q + 1'b1;
  assign wrap_d     = &prev_q;
  assign seq_d      = has_prev_q && (count == prev_inc_d);
  assign zero_d     = (count == '0);
  assign err_cnt_d  = (&err_cnt_q) ? err_cnt_q
                                   : err_cnt_q + 1'b1;

`ifdef COUNT_SEQ_CHECKER_WRAP_EN
  logic wrap_q;
  assign good_d     = seq_d;
  assign wrap_pulse = wrap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= good_d && wrap_d;
    end
  end
`else
  assign good_d     = seq_d && !wrap_d;
  assign wrap_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACQUIRE;
      prev_q     <= '0;
      has_prev_q <= 1'b0;
      run_q      <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      rst_pls_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      prev_q     <= count;
      has_prev_q <= 1'b1;
      err_q      <= 1'b0;
      rst_pls_q  <= 1'b0;
      unique case (state_q)
        ACQUIRE, SLIP: begin
          if (good_d) begin
            if (run_q == RUN_LAST) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              run_q    <= '0;
            end else begin
              run_q <= run_q + 1'b1;
            end
          end else begin
            run_q <= '0;
          end
        end
        LOCKED: begin
          if (!good_d) begin
            locked_q <= 1'b0;
            run_q    <= '0;
            // a zero out of sequence is a downstream restart, not a slip
            if (zero_d) begin
              rst_pls_q <= 1'b1;
              state_q   <= ACQUIRE;
            end else begin
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_d;
              state_q   <= SLIP;
            end
          end
        end
        default: begin
          state_q  <= ACQUIRE;
          locked_q <= 1'b0;
          run_q    <= '0;
        end
      endcase
    end
  end

  assign locked        = locked_q;
  assign err_pulse     = err_q;
  assign restart_pulse = rst_pls_q;
  assign err_count     = err_cnt_q;
  assign state         = state_q;

endmodule
